// File: rtl/interlock_axil_slave.sv
// AXI4-Lite slave with four 32-bit control registers that drive the interlock core.
// Define INTERLOCK_AXIL_SLVERR_EN to answer SLVERR for ADDR[5:4]!=0; otherwise those accesses alias onto regs 0-3.
module interlock_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg3
);
  localparam int NREG  = 4;
  localparam int NBYTE = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NREG-1:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic                          aw_held_q, aw_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                          w_held_q, w_held_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NBYTE-1:0]              w_strb_q, w_strb_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          rvalid_q, rvalid_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                          aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [NBYTE-1:0]              wr_strb;
  logic                          unused_bits;

  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit as soon as both halves are present, whether held or arriving this cycle.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign wr_addr = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;

`ifdef INTERLOCK_AXIL_SLVERR_EN
  assign wr_err = |wr_addr[C_S_AXI_ADDR_WIDTH-1:4];
  assign rd_err = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
      if (!wr_err) begin
        for (int b = 0; b < NBYTE; b++)
          if (wr_strb[b]) regs_d[wr_addr[3:2]][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Reads sample regs_q, so a same-edge write is seen only by the next read.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = rd_err ? '0 : regs_q[S_AXI_ARADDR[3:2]];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign ctrl_reg0    = regs_q[0];
  assign ctrl_reg1    = regs_q[1];
  assign ctrl_reg2    = regs_q[2];
  assign ctrl_reg3    = regs_q[3];
endmodule

// File: doc/interlock_axil_slave.md
INTERLOCK_AXIL_SLAVE -- requirements
Module: interlock_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte-address width of the 64-byte register window.
REQ-003 SHALL have port S_AXI_ACLK  in  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports S_AXI_AWADDR  in  6, S_AXI_AWPROT  in  3, S_AXI_AWVALID  in  1, S_AXI_AWREADY  out  1: the write-address channel (AWPROT ignored).
REQ-006 SHALL have ports S_AXI_WDATA  in  32, S_AXI_WSTRB  in  4, S_AXI_WVALID  in  1, S_AXI_WREADY  out  1: the write-data channel.
REQ-007 SHALL have ports S_AXI_BRESP  out  2, S_AXI_BVALID  out  1, S_AXI_BREADY  in  1: the write-response channel.
REQ-008 SHALL have ports S_AXI_ARADDR  in  6, S_AXI_ARPROT  in  3, S_AXI_ARVALID  in  1, S_AXI_ARREADY  out  1: the read-address channel (ARPROT ignored).
REQ-009 SHALL have ports S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID  out  1, S_AXI_RREADY  in  1: the read-data channel.
REQ-010 SHALL have ports ctrl_reg0..ctrl_reg3  out  32 each: live register contents driven to the interlock core.

Function
REQ-011 SHALL map the registers at word offsets 0x00, 0x04, 0x08, 0x0C and decode with ADDR[3:2]; ADDR[1:0] are ignored.
REQ-012 SHALL capture AW and W independently in one-entry holding buffers, in either order or in the same cycle.
REQ-013 SHALL drive AWREADY = !aw_held && !BVALID and WREADY = !w_held && !BVALID.
REQ-014 SHALL commit the write on the edge at which both AW and W are held (or handshaking) and assert BVALID from the next cycle, so write latency is 1 cycle after the later handshake.
REQ-015 SHALL update only the bytes whose WSTRB bit is set; WSTRB=0 SHALL leave the register unchanged but still produce a response.
REQ-016 SHALL hold BVALID and BRESP stable until BREADY; both holding buffers SHALL clear on the commit edge.
REQ-017 SHALL drive ARREADY = !RVALID, latch RDATA/RRESP on the AR handshake edge, and assert RVALID the next cycle.
REQ-018 SHALL hold RVALID, RDATA and RRESP stable until RREADY, so back-to-back reads take 2 cycles each minimum.
REQ-019 SHALL return the pre-write value when a read and a write to the same register complete on the same edge.
REQ-020 SHALL keep the read and write paths fully independent, with neither blocking the other.
REQ-021 SHALL update ctrl_regN on the commit edge, visible in the same cycle BVALID rises.

Reset
REQ-022 SHALL, while S_AXI_ARESETN=0, force all registers and ctrl_regN to 0, all READY/VALID outputs to 0 except AWREADY/WREADY/ARREADY (1 by REQ-013/017), BRESP/RRESP to 00, RDATA to 0, and holding buffers empty.
REQ-023 SHALL abandon any transaction in flight when reset asserts mid-transaction, with no partial register update and no response issued after release.

Configuration
REQ-024 SHALL use macro INTERLOCK_AXIL_SLVERR_EN to control decode of ADDR[5:4]!=0: when defined, such accesses return SLVERR (2'b10), writes are dropped and reads return 0; when undefined, ADDR[5:4] is ignored, accesses alias onto registers 0-3 via ADDR[3:2], and responses are OKAY.
REQ-025 SHALL respond OKAY (2'b00) to all in-range accesses in both builds.

Verification
REQ-026 SHALL cover: writes of 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C with WSTRB=0xF, then reads of the same addresses -> RDATA 0x1, 0x2, 0x3, 0x4, all RRESP=00, and ctrl_reg0..3 match.
REQ-027 SHALL cover: reg1=0xAABBCCDD, then a write of 0x11223344 with WSTRB=0x5 -> read of 0x04 returns 0xAA22CC44.
REQ-028 SHALL cover: W presented 3 cycles before AW, with BREADY held low for 4 cycles -> exactly one BVALID, held 4 cycles, and AWREADY/WREADY low throughout.
REQ-029 SHALL cover: a read of 0x08 on the same edge as a commit of 0x55 to 0x08 (old value 0x3) -> RDATA 0x3, and the next read returns 0x55.
REQ-030 SHALL cover: ARESETN pulsed low after the AW handshake but before W -> after release there is no BVALID, and all registers read 0.
REQ-031 SHALL cover: a write of 0xFF to 0x10 -> with the macro, BRESP=10 and reg0 unchanged; without it, BRESP=00 and reg0=0xFF.
